sram_burst_iface: RTL and testbench
===================================

SRAM_BURST_IFACE -- requirements
Module: sram_burst_iface

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the SRAM address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the SRAM data word width.
REQ-003 Parameter MAX_BURST, default 16, SHALL set the maximum words per request (power of 2); LEN_W = $clog2(MAX_BURST).
REQ-004 Parameter WAIT_CYCLES, default 2, SHALL set the cycles an enable is held per word (legal range 1..15).
REQ-005 Clocking SHALL be one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  system clock; all state changes on its rising edge.
REQ-007 n_rst  in  1  synchronous active-low reset.
REQ-008 start  in  1  request strobe; sampled only in IDLE.
REQ-009 writemode  in  1  1 = burst write, 0 = burst read; latched with start.
REQ-010 i_address  in  ADDR_W  first word address; latched with start.
REQ-011 i_burst_len  in  LEN_W  words minus one (0 = 1 word); latched with start.
REQ-012 i_w_data  in  DATA_W  write word; must be valid in the cycle w_req is high.
REQ-013 w_req  out  1  one-cycle pulse requesting the next write word.
REQ-014 i_r_data  out  DATA_W  last read word, held until the next capture.
REQ-015 r_valid  out  1  one-cycle pulse when i_r_data updates.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 io_done  out  1  one-cycle pulse at burst completion.
REQ-018 read_enable, write_enable  out  1 each  SRAM strobes.
REQ-019 address  out  ADDR_W  SRAM address.
REQ-020 w_data  out  DATA_W  SRAM write data (the tri-state driver is outside this block).
REQ-021 r_data  in  DATA_W  SRAM read data.

Function
REQ-022 The FSM SHALL have the states IDLE, SETUP, ACCESS and DONE.
REQ-023 IDLE with start=1 SHALL latch writemode, i_address and i_burst_len, load the remaining-word count to i_burst_len, and go to SETUP.
REQ-024 SETUP SHALL drive address from the latched pointer with both enables low; in write mode it SHALL pulse w_req and register i_w_data into w_data that same cycle; it then goes to ACCESS.
REQ-025 ACCESS SHALL assert write_enable (write mode) or read_enable (read mode) for exactly WAIT_CYCLES consecutive cycles, with address and w_data held stable.
REQ-026 In read mode, on the last ACCESS cycle the block SHALL register r_data into i_r_data and assert r_valid in the following cycle.
REQ-027 After the last ACCESS cycle, if words remain, the block SHALL increment the pointer, decrement the count and return to SETUP; otherwise it SHALL go to DONE.
REQ-028 The address pointer SHALL wrap modulo 2^ADDR_W (for example, 16'hFFFF followed by 16'h0000).
REQ-029 DONE SHALL pulse io_done for one cycle, keep both enables low and return to IDLE.
REQ-030 Each word SHALL take 1+WAIT_CYCLES cycles; total latency from the start-sampling edge to io_done SHALL be N*(1+WAIT_CYCLES)+1 cycles.
REQ-031 start outside IDLE, including in the DONE cycle, SHALL be ignored.
REQ-032 read_enable and write_enable SHALL never be high in the same cycle.
REQ-033 Both enables SHALL be low for at least one cycle (SETUP) between consecutive words.

Reset
REQ-034 On any clk edge with n_rst=0 the FSM SHALL go to IDLE.
REQ-035 On that edge busy, io_done, r_valid, w_req, read_enable and write_enable SHALL become 0, and address, w_data, i_r_data and the count SHALL become 0.
REQ-036 Reset mid-burst SHALL abandon the burst without producing io_done.

Structure
REQ-037 Package sram_pkg SHALL hold the state enum and the default ADDR_W and DATA_W constants.
REQ-038 The wait timing SHALL use one flex_counter instance (rollover value = WAIT_CYCLES); the word count and address pointer SHALL stay in the top-level RTL.

Verification
REQ-039 Single write: i_address=16'h00FA, data 32'h000000AB, len 0 -> write_enable high for 2 cycles at 16'h00FA; io_done at cycle 4; memory dump shows 16'h00FA=32'h000000AB.
REQ-040 Single read: i_address=16'h0001 preloaded with 32'h12345678 -> r_valid and i_r_data=32'h12345678 at cycle 4, together with io_done.
REQ-041 Four-word write burst at 16'hFFFE with data 1,2,3,4 -> addresses FFFE, FFFF, 0000, 0001 are written; 4 w_req pulses; io_done at cycle 13.
REQ-042 Start pulsed during a busy burst -> ignored; exactly one io_done is produced.
REQ-043 n_rst=0 during the second ACCESS of a read burst -> enables low on the next edge; no io_done; a subsequent request completes normally.
REQ-044 WAIT_CYCLES=1 build, 2-word read -> io_done at cycle 5; enables never high in consecutive words without a gap cycle between them.

Source files
------------

// File: rtl/sram_pkg.sv
// sram_pkg: shared types and default widths for the SRAM burst interface.
//   state_t      - burst controller FSM states
//   SRAM_ADDR_W  - default SRAM address width
//   SRAM_DATA_W  - default SRAM data word width
//   WAIT_CNT_W   - width of the per-word wait counter (wait range 1..15)
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SRAM_ADDR_W = 16;
  localparam int SRAM_DATA_W = 32;
  localparam int WAIT_CNT_W  = 4;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: programmable up-counter with a registered rollover flag.
//   clk, n_rst    - clock, synchronous active-low reset
//   clear         - synchronous clear to zero (priority over count_enable)
//   count_enable  - advance the count by one
//   rollover_val  - terminal count; the count restarts at 1 after reaching it
//   rollover_flag - high while the count equals rollover_val
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] count_q;
  logic [NUM_CNT_BITS-1:0] count_d;
  logic                    flag_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? NUM_CNT_BITS'(1)
                                          : count_q + NUM_CNT_BITS'(1);
    end
    // Flag is computed from the next count so it lines up with the count register.
    flag_d = !clear && (count_d == rollover_val);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_q       <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_q       <= count_d;
      rollover_flag <= flag_d;
    end
  end

endmodule

// File: rtl/sram_burst_iface.sv
// sram_burst_iface: burst read/write controller for an asynchronous SRAM.
// A request (start in IDLE) moves 1..MAX_BURST words starting at i_address.
// Each word spends one SETUP cycle (address/data settle, enables low) and
// WAIT_CYCLES ACCESS cycles (one enable high), followed after the last word
// by a single DONE cycle that pulses io_done.
//   clk, n_rst          - clock, synchronous active-low reset
//   start, writemode    - request strobe and direction (1 = write)
//   i_address           - first word address
//   i_burst_len         - words minus one
//   i_w_data / w_req    - write word supplied in the cycle w_req pulses
//   i_r_data / r_valid  - captured read word and its one-cycle valid pulse
//   busy, io_done       - not-idle indicator, completion pulse
//   read_enable, write_enable, address, w_data, r_data - SRAM side
module sram_burst_iface
  import sram_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int MAX_BURST   = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         start,
  input  logic                         writemode,
  input  logic [ADDR_W-1:0]            i_address,
  input  logic [$clog2(MAX_BURST)-1:0] i_burst_len,
  input  logic [DATA_W-1:0]            i_w_data,
  output logic                         w_req,
  output logic [DATA_W-1:0]            i_r_data,
  output logic                         r_valid,
  output logic                         busy,
  output logic                         io_done,
  output logic                         read_enable,
  output logic                         write_enable,
  output logic [ADDR_W-1:0]            address,
  output logic [DATA_W-1:0]            w_data,
  input  logic [DATA_W-1:0]            r_data
);

  localparam int LEN_W = $clog2(MAX_BURST);

  state_t              state_q;
  state_t              state_d;
  logic                wmode_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W-1:0]   r_data_q;
  logic                r_valid_q;

  logic                wait_flag;
  logic                last_access;
  logic                last_word;
  logic                wait_en;
  logic                wait_clr;

  // The counter runs through SETUP and ACCESS so its flag is already high in
  // the final ACCESS cycle; it restarts from zero at every word boundary.
  assign last_access = (state_q == ACCESS) && wait_flag;
  assign last_word   = (cnt_q == '0);
  assign wait_en     = (state_q == SETUP) || (state_q == ACCESS);
  assign wait_clr    = !wait_en || last_access;

  flex_counter #(
    .NUM_CNT_BITS (WAIT_CNT_W)
  ) u_wait_cnt (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (wait_clr),
    .count_enable  (wait_en),
    .rollover_val  (WAIT_CNT_W'(WAIT_CYCLES)),
    .rollover_flag (wait_flag)
  );

  always_comb begin
    state_d      = state_q;
    busy         = 1'b1;
    io_done      = 1'b0;
    w_req        = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = SETUP;
      end
      SETUP: begin
        w_req   = wmode_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        write_enable = wmode_q;
        read_enable  = !wmode_q;
        if (last_access) state_d = last_word ? DONE : SETUP;
      end
      DONE: begin
        io_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      wmode_q   <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      w_data_q  <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_valid_q <= last_access && !wmode_q;
      case (state_q)
        IDLE: begin
          if (start) begin
            wmode_q <= writemode;
            ptr_q   <= i_address;
            cnt_q   <= i_burst_len;
          end
        end
        SETUP: begin
          if (wmode_q) w_data_q <= i_w_data;
        end
        ACCESS: begin
          if (last_access) begin
            if (!wmode_q) r_data_q <= r_data;
            if (!last_word) begin
              // Pointer wraps naturally modulo 2^ADDR_W.
              ptr_q <= ptr_q + ADDR_W'(1);
              cnt_q <= cnt_q - LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign address  = ptr_q;
  assign w_data   = w_data_q;
  assign i_r_data = r_data_q;
  assign r_valid  = r_valid_q;

endmodule

// File: tb/tb_sram_burst_iface.sv
module tb_sram_burst_iface;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic          writemode;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_burst_len;
  logic [DW-1:0] i_w_data;
  logic          w_req;
  logic [DW-1:0] i_r_data;
  logic          r_valid;
  logic          busy;
  logic          io_done;
  logic          read_enable;
  logic          write_enable;
  logic [AW-1:0] address;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;

  // second instance built with WAIT_CYCLES = 1
  logic          start1;
  logic [AW-1:0] i_address1;
  logic [LW-1:0] i_burst_len1;
  logic          w_req1;
  logic [DW-1:0] i_r_data1;
  logic          r_valid1;
  logic          busy1;
  logic          io_done1;
  logic          read_enable1;
  logic          write_enable1;
  logic [AW-1:0] address1;
  logic [DW-1:0] w_data1;
  logic [DW-1:0] r_data1;

  always #5 clk = ~clk;

  sram_burst_iface #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .n_rst(n_rst), .start(start), .writemode(writemode),
    .i_address(i_address), .i_burst_len(i_burst_len), .i_w_data(i_w_data),
    .w_req(w_req), .i_r_data(i_r_data), .r_valid(r_valid), .busy(busy),
    .io_done(io_done), .read_enable(read_enable), .write_enable(write_enable),
    .address(address), .w_data(w_data), .r_data(r_data)
  );

  sram_burst_iface #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(16), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .n_rst(n_rst), .start(start1), .writemode(1'b0),
    .i_address(i_address1), .i_burst_len(i_burst_len1), .i_w_data(32'h0),
    .w_req(w_req1), .i_r_data(i_r_data1), .r_valid(r_valid1), .busy(busy1),
    .io_done(io_done1), .read_enable(read_enable1), .write_enable(write_enable1),
    .address(address1), .w_data(w_data1), .r_data(r_data1)
  );

  // SRAM model for the main instance, with a bench-side preload port
  logic [DW-1:0] mem [0:65535];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (write_enable) mem[address] <= w_data;
    else if (pre_we)  mem[pre_addr] <= pre_data;
  end
  assign r_data = mem[address];

  // fixed two-word contents for the WAIT_CYCLES = 1 instance
  assign r_data1 = (address1 == 16'h0030) ? 32'hC0FFEE00 :
                   (address1 == 16'h0031) ? 32'hC0FFEE01 : 32'h0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request on the main instance and observe it cycle by cycle.
  // Cycle k is the cycle after the k-th rising edge following the start-sampling edge.
  task automatic run_burst(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [DW-1:0] data0,
                           output int done_cyc, output int wreq_n, output int en_n,
                           output int rv_n, output int last_rv, output int seq_err,
                           output int prot_err);
    int  word;
    logic en, prev_en;
    done_cyc = -1; wreq_n = 0; en_n = 0; rv_n = 0; last_rv = -1;
    seq_err = 0; prot_err = 0; word = 0; prev_en = 1'b0;
    @(negedge clk);
    start = 1'b1; writemode = wr; i_address = addr; i_burst_len = len; i_w_data = '0;
    for (int k = 1; k <= 200 && done_cyc < 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) prot_err++;
      if (read_enable && write_enable) prot_err++;
      if (wr ? read_enable : write_enable) prot_err++;
      if (w_req) begin
        i_w_data = data0 + DW'(wreq_n);
        wreq_n++;
      end
      en = read_enable | write_enable;
      if (en) begin
        en_n++;
        if (address !== addr + AW'(word)) seq_err++;
        if (wr && (w_data !== data0 + DW'(word))) seq_err++;
      end
      if (prev_en && !en) word++;
      prev_en = en;
      if (r_valid) begin
        if (i_r_data !== data0 + DW'(rv_n)) seq_err++;
        rv_n++;
        last_rv = k;
      end
      if (io_done) done_cyc = k;
    end
    if (word != int'(len) + 1) seq_err++;
    @(negedge clk);
    if (busy || io_done) prot_err++;
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [DW-1:0] data0;
    int            exp_done;
    int            exp_wreq;
    int            exp_en;
    int            exp_rv;
    int            exp_last_rv;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int d, wq, en, rv, lrv, se, pe;
    int dones, done_at, gap_err;
    logic prev1;

    vecs[0] = '{1'b1, 16'h00FA, 4'd0,  32'h000000AB, 4,  1,  2,  0,  -1};
    vecs[1] = '{1'b0, 16'h0001, 4'd0,  32'h12345678, 4,  0,  2,  1,  4};
    vecs[2] = '{1'b1, 16'hFFFE, 4'd3,  32'h00000001, 13, 4,  8,  0,  -1};
    vecs[3] = '{1'b0, 16'hFFFE, 4'd3,  32'h00000001, 13, 0,  8,  4,  13};
    vecs[4] = '{1'b1, 16'h0010, 4'd15, 32'h00000100, 49, 16, 32, 0,  -1};
    vecs[5] = '{1'b0, 16'h0010, 4'd15, 32'h00000100, 49, 0,  32, 16, 49};

    n_rst = 1'b0; start = 1'b0; writemode = 1'b0; i_address = '0;
    i_burst_len = '0; i_w_data = '0;
    start1 = 1'b0; i_address1 = '0; i_burst_len1 = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_io_done", io_done, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_w_req", w_req, 0);
    check("rst_read_enable", read_enable, 0);
    check("rst_write_enable", write_enable, 0);
    check("rst_address", address, 0);
    check("rst_w_data", w_data, 0);
    check("rst_i_r_data", i_r_data, 0);
    n_rst = 1'b1;

    preload(16'h0001, 32'h12345678);

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].data0, d, wq, en, rv, lrv, se, pe);
      check($sformatf("v%0d_done_cycle", i), d, vecs[i].exp_done);
      check($sformatf("v%0d_w_req_count", i), wq, vecs[i].exp_wreq);
      check($sformatf("v%0d_enable_cycles", i), en, vecs[i].exp_en);
      check($sformatf("v%0d_r_valid_count", i), rv, vecs[i].exp_rv);
      check($sformatf("v%0d_last_r_valid_cycle", i), lrv, vecs[i].exp_last_rv);
      check($sformatf("v%0d_addr_data_seq_errs", i), se, 0);
      check($sformatf("v%0d_protocol_errs", i), pe, 0);
    end

    // memory dump after the write bursts
    check("mem_00FA", mem[16'h00FA], 32'h000000AB);
    check("mem_FFFE", mem[16'hFFFE], 32'h00000001);
    check("mem_FFFF", mem[16'hFFFF], 32'h00000002);
    check("mem_0000", mem[16'h0000], 32'h00000003);
    check("mem_0001", mem[16'h0001], 32'h00000004);
    check("mem_001F", mem[16'h001F], 32'h0000010F);

    // start pulsed mid-burst and again in the DONE cycle: both ignored
    @(negedge clk);
    start = 1'b1; writemode = 1'b1; i_address = 16'h0200; i_burst_len = 4'd1;
    dones = 0; done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = (k == 3) || io_done;
      if (w_req) i_w_data = (k == 1) ? 32'hA0 : 32'hA1;
      if (io_done) begin
        dones++;
        if (done_at < 0) done_at = k;
      end
    end
    start = 1'b0;
    check("ignore_start_done_count", dones, 1);
    check("ignore_start_done_cycle", done_at, 7);
    check("ignore_start_idle_after", busy, 0);
    check("ignore_start_mem_0201", mem[16'h0201], 32'hA1);

    // reset during the second word's ACCESS of a read burst
    @(negedge clk);
    start = 1'b1; writemode = 1'b0; i_address = 16'hFFFE; i_burst_len = 4'd1;
    dones = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) begin
        check("midrst_read_enable_before", read_enable, 1);
        n_rst = 1'b0;
      end
      if (k == 6) begin
        check("midrst_read_enable_after", read_enable, 0);
        check("midrst_write_enable_after", write_enable, 0);
        check("midrst_busy_after", busy, 0);
        n_rst = 1'b1;
      end
      if (io_done) dones++;
    end
    check("midrst_no_done", dones, 0);

    run_burst(1'b0, 16'h00FA, 4'd0, 32'h000000AB, d, wq, en, rv, lrv, se, pe);
    check("post_rst_done_cycle", d, 4);
    check("post_rst_r_valid_count", rv, 1);
    check("post_rst_seq_errs", se, 0);

    // WAIT_CYCLES = 1 instance, two-word read
    @(negedge clk);
    start1 = 1'b1; i_address1 = 16'h0030; i_burst_len1 = 4'd1;
    dones = 0; done_at = -1; gap_err = 0; en = 0; rv = 0; prev1 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (read_enable1 && prev1) gap_err++;
      if (write_enable1) gap_err++;
      prev1 = read_enable1;
      if (read_enable1) en++;
      if (r_valid1) begin
        if (i_r_data1 !== 32'hC0FFEE00 + DW'(rv)) gap_err++;
        rv++;
      end
      if (io_done1) begin
        dones++;
        if (done_at < 0) done_at = k;
      end
    end
    check("w1_done_cycle", done_at, 5);
    check("w1_done_count", dones, 1);
    check("w1_enable_cycles", en, 2);
    check("w1_r_valid_count", rv, 2);
    check("w1_gap_errs", gap_err, 0);
    check("w1_last_read", i_r_data1, 32'hC0FFEE01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
